ffe_ntap_prog: RTL
==================

// Module: ffe_ntap_prog
// PURPOSE
//  Parametrised N-tap feed-forward equaliser with run-time programmable coefficients.
//  Generational successor to the fixed 4-tap FFE; sits in the receive datapath after the ADC/sample loader.
//  Computes y[n] = sum_k c[k]*x[n-k] with rounding and saturation on a 2-stage pipeline.
//  Adds a bypass mode and a saturation flag.
// PARAMETERS
//  WIDTH   12  sample width, signed two's complement (input and output)
//  TAPS     8  number of taps, N >= 2
//  CW      12  coefficient width, signed
//  FRAC    10  coefficient fractional bits (c = 1<<FRAC means 1.0)
//  AW      $clog2(TAPS)  coefficient address width (derived localparam)
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  ffe_in_data    in   WIDTH   signed input sample
//  load_sig       in   1       sample valid; the delay line shifts only when high
//  coef_wr_en     in   1       coefficient write strobe
//  coef_wr_addr   in   AW      tap index to write
//  coef_wr_data   in   CW      signed coefficient value
//  bypass         in   1       1: output = input, delayed by the same latency
//  ffe_out_data   out  WIDTH   signed equalised sample
//  ffe_out_valid  out  1       1-cycle strobe per output sample
//  sat_flag       out  1       qualifies ffe_out_data: 1 if that sample was clipped
// BEHAVIOUR
//  - Reset values:
//    - delay line x[0..N-1] = 0
//    - c[0] = 1<<FRAC, c[1..N-1] = 0 (identity filter)
//    - ffe_out_data = 0, ffe_out_valid = 0, sat_flag = 0
//    - all pipeline valid bits cleared; in-flight samples are discarded on reset mid-stream.
//  - Delay line: on a clk edge with load_sig=1, x[0] <= ffe_in_data and x[k] <= x[k-1].
//    With load_sig=0 the line holds; gaps in load_sig never corrupt the history.
//  - Stage 1, on the edge after load: register the N products p[k] = c[k]*x[k]
//    (WIDTH+CW bits each, signed), using the updated line. Also register v1 and bypass sample.
//  - Stage 2: acc = sum p[k], width WIDTH+CW+AW, no overflow possible.
//    - Round half-up: r = (acc + (1<<(FRAC-1))) >>> FRAC (arithmetic).
//    - Saturate r to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; sat_flag=1 iff clipped.
//    - Register ffe_out_data, sat_flag and ffe_out_valid = v1.
//  - Latency: ffe_out_valid rises exactly 2 clk edges after the edge sampling load_sig=1.
//    Throughput is 1 sample/cycle; back-to-back loads give back-to-back valids.
//  - ffe_out_data holds its last value while ffe_out_valid=0. sat_flag is meaningful only with valid.
//  - Coefficient write: c[coef_wr_addr] <= coef_wr_data on the edge.
//    - If write and load_sig coincide, that sample's stage-1 products use the OLD coefficient.
//      The new value applies from the next loaded sample.
//    - coef_wr_addr >= TAPS (TAPS not a power of 2): write ignored.
//  - bypass=1: ffe_out_data = sample loaded 2 edges earlier, sat_flag=0, same valid timing.
//    bypass is sampled with the load, so a toggle mid-stream affects only subsequently loaded samples.
//  - No state machine; control is the valid pipeline (v1, v2) only.
// STRUCTURE
//  - Shared package ffe_pkg: default WIDTH/TAPS/CW/FRAC, the function sat_round(acc) -> {sat, data},
//    and the localparam COEF_ONE = 1<<FRAC.
//  - One sub-module ffe_coef_bank: TAPS x CW register file.
//    - Async reset to identity; write port; flat parallel read bus.
//  - Top holds the delay line, product regs, adder tree, round/saturate and valid pipe.
//  - Target 150-250 lines total.
// TESTING  (defaults, clk period 100, rst pulsed high then low)
//  1 Reset identity: load 64,128,-64 on consecutive cycles
//    -> valid on cycles +2..+4, data 64,128,-64, sat_flag=0.
//  2 Program c0=1024, c1=512: load 64 then 128
//    -> outputs 64 then 160 (128+32); rounding check: c1=1, x=512 -> +1 after round-half-up.
//  3 Saturation: c0=2047, load 2047 then -2048
//    -> outputs 2047 sat=1, then -2048 sat=1.
//  4 Load gaps: load 64, idle 3 cycles, load 128 with c1=512
//    -> second output 160 (history held), valid exactly 2 cycles after each load.
//  5 Same-cycle write c0=512 with load of 100 (c0 was 1024)
//    -> output 100; next load of 100 -> 50.
//  6 Reset mid-stream after 2 back-to-back loads
//    -> no valid emitted, outputs 0, coefficients back to identity; bypass=1 load 300 -> 300 at +2.

Source files
------------

// File: rtl/ffe_pkg.sv
// Shared defaults and the round/saturate helper used by the N-tap feed-forward equaliser.
package ffe_pkg;

    localparam int DEF_WIDTH = 12;
    localparam int DEF_TAPS  = 8;
    localparam int DEF_CW    = 12;
    localparam int DEF_FRAC  = 10;
    localparam int COEF_ONE  = 1 << DEF_FRAC;
    localparam int RND_W     = 64;

    typedef struct packed {
        logic                    sat;
        logic signed [RND_W-1:0] data;
    } sat_res_t;

    // Round half-up at the binary point, then clip to a signed width-bit range.
    function automatic sat_res_t sat_round(
        input logic signed [RND_W-1:0] acc,
        input int                      width,
        input int                      frac
    );
        logic signed [RND_W-1:0] r;
        logic signed [RND_W-1:0] hi;
        logic signed [RND_W-1:0] lo;
        sat_res_t                res;
        r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (r > hi) begin
            res.sat  = 1'b1;
            res.data = hi;
        end else if (r < lo) begin
            res.sat  = 1'b1;
            res.data = lo;
        end else begin
            res.sat  = 1'b0;
            res.data = r;
        end
        return res;
    endfunction

endpackage

// File: rtl/ffe_coef_bank.sv
// TAPS x CW coefficient register file; resets to the identity filter (c0 = 1.0, others 0).
module ffe_coef_bank
    import ffe_pkg::*;
#(
    parameter int  TAPS = DEF_TAPS,
    parameter int  CW   = DEF_CW,
    parameter int  FRAC = DEF_FRAC,
    localparam int AW   = $clog2(TAPS)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coef_wr_en,
    input  logic [AW-1:0]        coef_wr_addr,
    input  logic [CW-1:0]        coef_wr_data,
    output logic [TAPS*CW-1:0]   coef_flat
);

    localparam logic [CW-1:0] ONE = CW'(1) << FRAC;

    logic [CW-1:0] coef_q [TAPS];

    // Addresses beyond the last tap match no entry, so such writes fall away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k] <= (k == 0) ? ONE : '0;
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (coef_wr_en && (coef_wr_addr == AW'(k))) begin
                    coef_q[k] <= coef_wr_data;
                end
            end
        end
    end

    for (genvar g = 0; g < TAPS; g++) begin : g_flat
        assign coef_flat[g*CW +: CW] = coef_q[g];
    end

endmodule

// File: rtl/ffe_ntap_prog.sv
// N-tap FFE: delay line, registered products, adder, round/saturate and a 2-deep valid pipe.
module ffe_ntap_prog
    import ffe_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  TAPS  = DEF_TAPS,
    parameter int  CW    = DEF_CW,
    parameter int  FRAC  = DEF_FRAC,
    localparam int AW    = $clog2(TAPS)
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] ffe_in_data,
    input  logic                    load_sig,
    input  logic                    coef_wr_en,
    input  logic [AW-1:0]           coef_wr_addr,
    input  logic [CW-1:0]           coef_wr_data,
    input  logic                    bypass,
    output logic signed [WIDTH-1:0] ffe_out_data,
    output logic                    ffe_out_valid,
    output logic                    sat_flag
);

    localparam int                 PW       = WIDTH + CW;
    localparam int                 ACC_W    = PW + AW;
    localparam logic [CW-1:0]      ONE      = CW'(1) << FRAC;
    localparam logic [TAPS*CW-1:0] COEF_RST = {{((TAPS-1)*CW){1'b0}}, ONE};

    logic [TAPS*CW-1:0]      coef_flat;
    logic [TAPS*CW-1:0]      coef_snap;
    logic signed [WIDTH-1:0] x_line [TAPS];
    logic                    v0;
    logic                    byp0;
    logic signed [PW-1:0]    coef_ext [TAPS];
    logic signed [PW-1:0]    prod [TAPS];
    logic                    v1;
    logic                    byp1;
    logic signed [WIDTH-1:0] byp_data1;
    logic signed [ACC_W-1:0] acc;
    sat_res_t                rnd;

    ffe_coef_bank #(
        .TAPS (TAPS),
        .CW   (CW),
        .FRAC (FRAC)
    ) u_coef_bank (
        .clk          (clk),
        .rst          (rst),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_addr (coef_wr_addr),
        .coef_wr_data (coef_wr_data),
        .coef_flat    (coef_flat)
    );

    // The coefficient snapshot is taken with the sample, so a write on the same
    // edge only affects later samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                x_line[k] <= '0;
            end
            coef_snap <= COEF_RST;
            v0        <= 1'b0;
            byp0      <= 1'b0;
        end else begin
            v0 <= load_sig;
            if (load_sig) begin
                x_line[0] <= ffe_in_data;
                for (int k = 1; k < TAPS; k++) begin
                    x_line[k] <= x_line[k-1];
                end
                coef_snap <= coef_flat;
                byp0      <= bypass;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            coef_ext[k] = PW'(signed'(coef_snap[k*CW +: CW]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                prod[k] <= '0;
            end
            v1        <= 1'b0;
            byp1      <= 1'b0;
            byp_data1 <= '0;
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                prod[k] <= PW'(x_line[k]) * coef_ext[k];
            end
            v1        <= v0;
            byp1      <= byp0;
            byp_data1 <= x_line[0];
        end
    end

    // AW guard bits make the sum of TAPS full-scale products overflow-free.
    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc = acc + ACC_W'(prod[k]);
        end
        rnd = sat_round(RND_W'(acc), WIDTH, FRAC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ffe_out_data  <= '0;
            sat_flag      <= 1'b0;
            ffe_out_valid <= 1'b0;
        end else begin
            ffe_out_valid <= v1;
            if (v1) begin
                if (byp1) begin
                    ffe_out_data <= byp_data1;
                    sat_flag     <= 1'b0;
                end else begin
                    ffe_out_data <= WIDTH'(rnd.data);
                    sat_flag     <= rnd.sat;
                end
            end
        end
    end

endmodule
